cordic_vectoring: RTL
=====================

CORDIC_VECTORING -- requirements
Module: cordic_vectoring

Interface
REQ-001 SHALL have parameter ITER, default 12, meaning the number of micro-rotation iterations (legal range 8..14).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port start, input, 1 bit: request pulse, sampled only in IDLE.
REQ-005 SHALL have ports x_in and y_in, input, 16 bits each: signed Q2.14 Cartesian operands, captured on the edge that accepts start.
REQ-006 SHALL have port busy, output, 1 bit: high from the edge after start is accepted until the edge on which done rises.
REQ-007 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-008 SHALL have port magnitude, output, 16 bits: non-negative Q3.13 value of sqrt(x²+y²).
REQ-009 SHALL have port phase, output, 16 bits: signed Q3.13 radians value of atan2(y,x), in the range (-π, +π].

Function
REQ-010 SHALL implement an FSM with states IDLE, PRE, ITER, SCALE and OUT.
REQ-011 IDLE: start=1 SHALL capture x_in and y_in and go to PRE; start=0 SHALL stay in IDLE.
REQ-012 PRE: the block SHALL sign-extend the operands to an 18-bit Q4.14 internal x,y and perform quadrant folding, then go to ITER with the iteration counter i=0.
- x≥0: x,y unchanged; z=0.
- x<0, y≥0: x'=y, y'=-x, z=+π/2 (0x3244).
- x<0, y<0: x'=-y, y'=x, z=-π/2 (0xCDBC).
REQ-013 ITER: the block SHALL perform one micro-rotation per cycle, using arithmetic shifts by i.
- y≥0: x+=y>>>i, y-=x>>>i, z+=atan(2^-i).
- y<0: x-=y>>>i, y+=x>>>i, z-=atan(2^-i).
- All right-hand sides use pre-update values.
- Go to SCALE after i=ITER-1.
REQ-014 SCALE: the block SHALL multiply x by 0x26DD (0.607253, Q2.14) and convert the product to Q3.13 by truncation (product>>>15).
- The result SHALL saturate to 0x7FFF.
- z SHALL be held.
REQ-015 OUT: the block SHALL register magnitude and phase, pulse done=1 for exactly one cycle, deassert busy, and return to IDLE.
REQ-016 Latency SHALL be exactly ITER+3 cycles from the start-accepting edge to the edge on which done rises (15 for ITER=12).
REQ-017 magnitude and phase SHALL hold their values between done pulses; no other output changes outside OUT or reset.
REQ-018 start asserted while busy SHALL be ignored, with no queuing.
REQ-019 start asserted in the same cycle done pulses SHALL be ignored; a new start is accepted from IDLE only, so back-to-back throughput is one result per ITER+4 cycles.
REQ-020 x_in=y_in=0 SHALL yield magnitude=0x0000 and phase=0x0000.
REQ-021 x<0 with y=0 SHALL yield phase=+π (0x6488), never -π.
REQ-022 Input -2.0 (0x8000) on either operand SHALL be handled without internal overflow; the 18-bit datapath provides the headroom.

Reset
REQ-023 rst=0 SHALL force the state to IDLE, counter to 0, busy=0, done=0, magnitude=0x0000, phase=0x0000 and internal x/y/z to 0, asynchronously.
REQ-024 Reset asserted mid-operation SHALL abort the computation; no done pulse follows reset release without a new start.
REQ-025 The first start SHALL be accepted no earlier than the first rising edge after reset deasserts.

Structure
REQ-026 A shared package cordic_pkg SHALL hold the following:
- the gain constant 0x26DD;
- PI_HALF 0x3244 and PI 0x6488 (Q3.13);
- the Q3.13 atan(2^-i) table for i=0..13 (0x1922, 0x0ED6, 0x07D7, 0x03FB, ...);
- the FSM state enum.
REQ-027 A single combinational sub-module, cordic_vec_stage, SHALL implement one micro-rotation (inputs x, y, z, i; outputs next x, y, z) and be instantiated once and iterated in time.

Verification
REQ-028 The bench SHALL check x=0x4000, y=0x0000 -> magnitude 0x2000±8, phase 0x0000±8, done exactly 15 cycles after start.
REQ-029 The bench SHALL check x=0x0000, y=0x4000 -> magnitude 0x2000±8, phase 0x3244±8; and x=0x0000, y=0xC000 -> phase 0xCDBC±8.
REQ-030 The bench SHALL check x=0xC000, y=0x0000 -> phase 0x6488±8 (positive), magnitude 0x2000±8.
REQ-031 The bench SHALL check x=0x2D41, y=0x2D41 -> magnitude 0x2000±8, phase 0x1922±8; and x=y=0 -> both outputs 0x0000.
REQ-032 The bench SHALL check that a second start pulsed at cycle 5 of a computation is ignored: exactly one done, and outputs match the first operands.
REQ-033 The bench SHALL check that rst=0 at cycle 7 of a computation clears all outputs immediately, and that no done follows within 20 cycles after release.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants, atan table and FSM states for the CORDIC vectoring block
`timescale 1ns/1ps
package cordic_pkg;
    localparam logic signed [15:0] GAIN    = 16'sh26DD;
    localparam logic signed [15:0] PI_HALF = 16'sh3244;
    localparam logic signed [15:0] PI      = 16'sh6488;
    localparam logic signed [15:0] ATAN_TAB [14] = '{
        16'sh1922, 16'sh0ED6, 16'sh07D7, 16'sh03FB, 16'sh01FF, 16'sh0100, 16'sh0080,
        16'sh0040, 16'sh0020, 16'sh0010, 16'sh0008, 16'sh0004, 16'sh0002, 16'sh0001
    };
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ITER, S_SCALE, S_OUT} state_t;
    function automatic logic signed [15:0] atan_lut(input logic [3:0] i);
        return (i < 4'd14) ? ATAN_TAB[i] : 16'sd0;
    endfunction
endpackage

// File: rtl/cordic_vec_stage.sv
// cordic_vec_stage: one combinational vectoring micro-rotation
// ports: x,y (Q4.14), z (Q3.13), i (shift index) -> x_nxt, y_nxt, z_nxt
`timescale 1ns/1ps
module cordic_vec_stage
    import cordic_pkg::*;
(
    input  logic signed [17:0] x,
    input  logic signed [17:0] y,
    input  logic signed [15:0] z,
    input  logic        [3:0]  i,
    output logic signed [17:0] x_nxt,
    output logic signed [17:0] y_nxt,
    output logic signed [15:0] z_nxt
);
    logic signed [17:0] x_sh, y_sh;
    logic signed [15:0] a;
    logic               up;
    assign x_sh  = x >>> i;
    assign y_sh  = y >>> i;
    assign a     = atan_lut(i);
    assign up    = ~y[17];
    assign x_nxt = up ? x + y_sh : x - y_sh;
    assign y_nxt = up ? y - x_sh : y + x_sh;
    assign z_nxt = up ? z + a : z - a;
endmodule

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative CORDIC converting (x,y) Q2.14 to magnitude/phase Q3.13
// ports: clk, rst (async, active-low), start, x_in, y_in -> busy, done, magnitude, phase
`timescale 1ns/1ps
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int ITER = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] magnitude,
    output logic [15:0] phase
);
    state_t             state, state_nxt;
    logic        [3:0]  cnt;
    logic signed [17:0] x, y, x_nxt, y_nxt;
    logic signed [15:0] z, z_nxt;
    logic signed [33:0] prod;
    logic        [15:0] scaled;
    logic               zero;

    cordic_vec_stage u_stage (
        .x     (x),
        .y     (y),
        .z     (z),
        .i     (cnt),
        .x_nxt (x_nxt),
        .y_nxt (y_nxt),
        .z_nxt (z_nxt)
    );

    assign prod = (34'(x) * 34'(GAIN)) >>> 15;

    // done is high during the first IDLE cycle, so a start there is dropped
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  state_nxt = (start && !done) ? S_PRE : S_IDLE;
            S_PRE:   state_nxt = S_ITER;
            S_ITER:  state_nxt = (cnt == 4'(ITER - 1)) ? S_SCALE : S_ITER;
            S_SCALE: state_nxt = S_OUT;
            S_OUT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            zero      <= 1'b0;
            scaled    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            magnitude <= '0;
            phase     <= '0;
        end else begin
            state <= state_nxt;
            done  <= state == S_OUT;
            unique case (state)
                S_IDLE: begin
                    if (start && !done) begin
                        x    <= {{2{x_in[15]}}, x_in};
                        y    <= {{2{y_in[15]}}, y_in};
                        busy <= 1'b1;
                    end
                end
                S_PRE: begin
                    // fold into the right half-plane so the iterations converge
                    x    <= !x[17] ? x : (!y[17] ? y : -y);
                    y    <= !x[17] ? y : (!y[17] ? -x : x);
                    z    <= !x[17] ? 16'sd0 : (!y[17] ? PI_HALF : -PI_HALF);
                    zero <= x == 18'sd0 && y == 18'sd0;
                    cnt  <= '0;
                end
                S_ITER: begin
                    x   <= x_nxt;
                    y   <= y_nxt;
                    z   <= z_nxt;
                    cnt <= cnt + 4'd1;
                end
                S_SCALE: scaled <= (|prod[33:15]) ? 16'h7FFF : prod[15:0];
                S_OUT: begin
                    magnitude <= scaled;
                    // a zero vector would otherwise leave the accumulated atan sum in z
                    phase     <= zero ? 16'h0000 : z;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
